ext_pipe_unit: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate extender in the MIPS datapath.
- Accepts an IN_W-bit immediate plus a 2-bit mode, and produces an OUT_W-bit extended result one cycle later over a valid/ready handshake.
- A 2-entry skid buffer lets the decode stage stall without losing data.
- Feeds the ALU-B mux and the branch-target adder in the pipelined core.

---
 rtl/ext_pipe_unit.sv | 94 +++++++++
 tb/tb_ext_pipe_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe_unit.sv
// Pipelined immediate extender with a valid/ready handshake and a 2-entry skid buffer.
// Produces ZERO / SIGN / UPPER / SIGN_SHL2 extensions for the ALU-B mux and branch adder.
module ext_pipe_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext_out,
    output logic             ext_sign,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        MODE_ZERO      = 2'd0,
        MODE_SIGN      = 2'd1,
        MODE_UPPER     = 2'd2,
        MODE_SIGN_SHL2 = 2'd3
    } mode_t;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] result;

    logic             m_valid;
    logic [OUT_W-1:0] m_data;
    logic             k_valid;
    logic [OUT_W-1:0] k_data;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             consume;

    always_comb begin
        sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        result = {{(OUT_W-IN_W){1'b0}}, imm};
        case (mode_t'(mode))
            MODE_ZERO:      result = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_SIGN:      result = sext;
            MODE_UPPER:     result = {imm, {(OUT_W-IN_W){1'b0}}};
            MODE_SIGN_SHL2: result = {sext[OUT_W-3:0], 2'b00};
            default:        result = {{(OUT_W-IN_W){1'b0}}, imm};
        endcase
    end

    // in_ready depends only on the skid flop, so there is no out_ready -> in_ready path.
    assign in_ready  = !k_valid;
    assign accept    = in_valid && in_ready;
    assign consume   = m_valid && out_ready;

    assign out_valid = m_valid;
    assign ext_out   = m_data;
    assign ext_sign  = m_data[OUT_W-1];
    assign xfer_cnt  = cnt;

    // M feeds the output; K only fills when M is occupied and not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            k_valid <= 1'b0;
            k_data  <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (accept) begin
                if ((!m_valid || consume) && !k_valid) begin
                    m_data  <= result;
                    m_valid <= 1'b1;
                end else begin
                    k_data  <= result;
                    k_valid <= 1'b1;
                end
            end else if (consume) begin
                if (k_valid) begin
                    m_data  <= k_data;
                    k_valid <= 1'b0;
                end else begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Directed-vector and scoreboard bench for ext_pipe_unit (IN_W=16, OUT_W=32, CNT_W=16).
module tb_ext_pipe_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_out;
    logic        ext_sign;
    logic [15:0] xfer_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [12];

    logic [31:0] q [$];
    logic [15:0] exp_cnt;

    ext_pipe_unit #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_out   (ext_out),
        .ext_sign  (ext_sign),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension written with signed arithmetic rather than bit concatenation.
    function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] m);
        logic signed [15:0] si;
        logic signed [31:0] s;
        si = i;
        s  = si;
        case (m)
            2'd0:    return {16'h0000, i};
            2'd1:    return s;
            2'd2:    return {i, 16'h0000};
            default: return s <<< 2;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] i, input logic [1:0] m, input logic r);
        in_valid  = v;
        imm       = i;
        mode      = m;
        out_ready = r;
    endtask

    initial begin
        int bad;
        logic hold;
        logic acc;
        logic con;

        vecs[0]  = '{16'h8001, 2'd1, 32'hFFFF8001};
        vecs[1]  = '{16'hFFFC, 2'd0, 32'h0000FFFC};
        vecs[2]  = '{16'hFFFC, 2'd1, 32'hFFFFFFFC};
        vecs[3]  = '{16'hFFFC, 2'd2, 32'hFFFC0000};
        vecs[4]  = '{16'hFFFC, 2'd3, 32'hFFFFFFF0};
        vecs[5]  = '{16'h7FFF, 2'd1, 32'h00007FFF};
        vecs[6]  = '{16'h7FFF, 2'd3, 32'h0001FFFC};
        vecs[7]  = '{16'h1234, 2'd2, 32'h12340000};
        vecs[8]  = '{16'h8000, 2'd3, 32'hFFFE0000};
        vecs[9]  = '{16'h8000, 2'd0, 32'h00008000};
        vecs[10] = '{16'h0000, 2'd1, 32'h00000000};
        vecs[11] = '{16'h0001, 2'd3, 32'h00000004};

        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0);
        #12;
        rst = 1'b0;
        step();

        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("reset_ext_out",   ext_out,            32'h0);
        checkOutput("reset_ext_sign",  {31'b0, ext_sign},  32'd0);
        checkOutput("reset_xfer_cnt",  {16'b0, xfer_cnt},  32'd0);

        // Back-to-back table vectors: each result must appear exactly one cycle after accept.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].imm, vecs[i].mode, 1'b1);
            step();
            checkOutput($sformatf("vec%0d_ext_out", i), ext_out, vecs[i].expected);
            checkOutput($sformatf("vec%0d_ext_sign", i), {31'b0, ext_sign}, {31'b0, vecs[i].expected[31]});
            checkOutput($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d_xfer_cnt", i), {16'b0, xfer_cnt}, i + 1);
        end
        applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
        step();
        checkOutput("drain_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("drain_ext_held", ext_out, 32'h00000004);

        // Stall: two accepts fill M and K, the third is held off until out_ready rises.
        applyStimulus(1'b1, 16'h0001, 2'd0, 1'b0);
        step();
        checkOutput("stall_first_ext", ext_out, 32'h00000001);
        checkOutput("stall_first_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 16'h0002, 2'd0, 1'b0);
        step();
        checkOutput("stall_full_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("stall_full_ext", ext_out, 32'h00000001);
        applyStimulus(1'b1, 16'h0003, 2'd0, 1'b0);
        step();
        checkOutput("stall_held_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("stall_held_ext", ext_out, 32'h00000001);
        checkOutput("stall_held_cnt", {16'b0, xfer_cnt}, 32'd14);
        out_ready = 1'b1;
        step();
        checkOutput("release_out2", ext_out, 32'h00000002);
        checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        checkOutput("release_out3", ext_out, 32'h00000003);
        checkOutput("release_cnt", {16'b0, xfer_cnt}, 32'd15);
        in_valid = 1'b0;
        step();
        checkOutput("release_empty", {31'b0, out_valid}, 32'd0);
        checkOutput("release_held_ext", ext_out, 32'h00000003);

        // Asynchronous reset with both entries full.
        applyStimulus(1'b1, 16'h00AA, 2'd0, 1'b0);
        step();
        imm = 16'h00BB;
        step();
        checkOutput("prereset_full", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset_xfer_cnt", {16'b0, xfer_cnt}, 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("postreset_in_ready", {31'b0, in_ready}, 32'd1);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        checkOutput("postreset_no_stale", bad, 32'd0);

        // Random handshake traffic against a queue model of M+K occupancy.
        exp_cnt = 16'h0000;
        bad = 0;
        hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                imm      = 16'($urandom);
                mode     = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid !== (q.size() > 0)) bad++;
            if (in_ready !== (q.size() < 2)) bad++;
            if (xfer_cnt !== exp_cnt) bad++;
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (con) begin
                if (q.size() == 0) bad++;
                else begin
                    if (ext_out !== q[0] || ext_sign !== q[0][31]) bad++;
                    void'(q.pop_front());
                end
            end
            if (acc) begin
                q.push_back(ref_ext(imm, mode));
                exp_cnt = exp_cnt + 16'd1;
            end
            hold = in_valid && !in_ready;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid !== (q.size() > 0)) bad++;
            if (out_valid && q.size() > 0) begin
                if (ext_out !== q[0]) bad++;
                void'(q.pop_front());
            end
            step();
        end
        checkOutput("random_scoreboard_errors", bad, 32'd0);
        checkOutput("random_leftover_items", q.size(), 32'd0);
        checkOutput("random_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt});

        // Stream transfers until the counter sits at its maximum, then wrap it.
        applyStimulus(1'b1, 16'h0005, 2'd0, 1'b1);
        for (int c = 0; c < 70000 && exp_cnt != 16'hFFFF; c++) begin
            if (in_ready) exp_cnt = exp_cnt + 16'd1;
            step();
        end
        checkOutput("cnt_at_max", {16'b0, xfer_cnt}, 32'h0000FFFF);
        step();
        checkOutput("cnt_wrapped", {16'b0, xfer_cnt}, 32'h00000000);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
